// File: rtl/mult_prod_accumulator_if.sv
// Stream bundle between the 4x4 multiplier and the product accumulator:
// an input product stream and an output group-result stream.
interface mult_prod_accumulator_if #(
   parameter int PW = 8,
   parameter int AW = 16,
   parameter int CW = 5
);
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_prod;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic [CW-1:0] out_count;
   logic          out_ovf;
   logic          out_forced;

   // Accumulator side: consumes products, produces group results.
   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf, out_forced
   );

   // Environment side: produces products, consumes group results.
   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf, out_forced
   );
endinterface

// File: rtl/mult_prod_accumulator.sv
// Group-wise reduction of an unsigned product stream into a wide sum.
// A group closes on in_last or after MAX_TERMS beats; its result is held
// in registers until the sink takes it, during which no beats are accepted.
module mult_prod_accumulator #(
   parameter int PW        = 8,
   parameter int AW        = 16,
   parameter int MAX_TERMS = 16,
   parameter int SAT       = 1,
   localparam int CW       = $clog2(MAX_TERMS + 1)
) (
   input  logic clk,
   input  logic rst_n,
   mult_prod_accumulator_if.slave bus
);

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          out_valid_q, out_valid_d;
   logic [AW-1:0] out_sum_q, out_sum_d;
   logic [CW-1:0] out_count_q, out_count_d;
   logic          out_ovf_q, out_ovf_d;
   logic          out_forced_q, out_forced_d;

   logic [AW:0]   sum_s;
   logic [AW-1:0] acc_upd_s;
   logic [CW-1:0] cnt_upd_s;
   logic          ovf_upd_s;
   logic          close_s;

   // Post-beat accumulator value with one carry bit, clamped or wrapped on overflow.
   always_comb begin
      sum_s     = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, bus.in_prod};
      cnt_upd_s = cnt_q + CW'(1);
      ovf_upd_s = ovf_q | sum_s[AW];
      close_s   = bus.in_last | (cnt_upd_s == CW'(MAX_TERMS));
      if (sum_s[AW]) begin
         if (SAT != 0) begin
            acc_upd_s = {AW{1'b1}};
         end else begin
            acc_upd_s = sum_s[AW-1:0];
         end
      end else begin
         acc_upd_s = sum_s[AW-1:0];
      end
   end

   // Next-state and result capture for the ACC/HOLD controller.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      out_valid_d  = out_valid_q;
      out_sum_d    = out_sum_q;
      out_count_d  = out_count_q;
      out_ovf_d    = out_ovf_q;
      out_forced_d = out_forced_q;
      case (state_q)
         ST_ACC: begin
            // in_ready is high in ACC, so a valid beat is always a transfer.
            if (bus.in_valid) begin
               if (close_s) begin
                  out_sum_d    = acc_upd_s;
                  out_count_d  = cnt_upd_s;
                  out_ovf_d    = ovf_upd_s;
                  out_forced_d = ~bus.in_last;
                  out_valid_d  = 1'b1;
                  acc_d        = {AW{1'b0}};
                  cnt_d        = {CW{1'b0}};
                  ovf_d        = 1'b0;
                  state_d      = ST_HOLD;
               end else begin
                  acc_d = acc_upd_s;
                  cnt_d = cnt_upd_s;
                  ovf_d = ovf_upd_s;
               end
            end else begin
               state_d = ST_ACC;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACC;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_ACC;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State, accumulator and result registers; reset discards any partial group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ACC;
         acc_q        <= {AW{1'b0}};
         cnt_q        <= {CW{1'b0}};
         ovf_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sum_q    <= {AW{1'b0}};
         out_count_q  <= {CW{1'b0}};
         out_ovf_q    <= 1'b0;
         out_forced_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         out_valid_q  <= out_valid_d;
         out_sum_q    <= out_sum_d;
         out_count_q  <= out_count_d;
         out_ovf_q    <= out_ovf_d;
         out_forced_q <= out_forced_d;
      end
   end

   assign bus.in_ready   = (state_q == ST_ACC);
   assign bus.out_valid  = out_valid_q;
   assign bus.out_sum    = out_sum_q;
   assign bus.out_count  = out_count_q;
   assign bus.out_ovf    = out_ovf_q;
   assign bus.out_forced = out_forced_q;

endmodule
